// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-access pipeline stage with dmem req/ack sequencing and MEM/WB register
//
// Sits after the EX/MEM register. Resolves branches combinationally while idle,
// runs one load/store per instruction over a registered req/ack handshake
// (stalling upstream while the access is outstanding), and owns the MEM/WB
// register that feeds writeback.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Branch_in .. MemtoReg_in control bits from EX/MEM
//   PC_calculated_in         branch target
//   ALU_result_in            address / ALU result (zero = branch taken)
//   Read_data1_in            store data
//   Register_dest_in         destination register
//   dmem_req/we/addr/wdata   registered request to data memory
//   dmem_ack, dmem_rdata     completion and load data (valid with ack)
//   stall                    freeze PC, IF/ID, ID/EX, EX/MEM
//   PCSrc, PC_target         branch redirect
//   flush_out                flush younger stages (same as PCSrc)
//   bus_error                sticky request timeout flag
//   RegWrite_out .. Register_dest_out  MEM/WB register
//   misalign                 sticky misaligned-access flag (MEM_MISALIGN_CHECK_EN only)
//
// Optional build macro: MEM_MISALIGN_CHECK_EN
//   When defined, a memory op whose address is not word aligned is never
//   issued; it is retired through DONE with its register write suppressed and
//   the sticky misalign output set.

module mem_stage_ctrl #(
    parameter int Width   = 32,
    parameter int Depth   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic             RegWrite_in,
    input  logic             MemtoReg_in,
    input  logic [Width-1:0] PC_calculated_in,
    input  logic [Depth-1:0] ALU_result_in,
    input  logic [Depth-1:0] Read_data1_in,
    input  logic [4:0]       Register_dest_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [Depth-1:0] dmem_addr,
    output logic [Depth-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [Depth-1:0] dmem_rdata,
    output logic             stall,
    output logic             PCSrc,
    output logic [Width-1:0] PC_target,
    output logic             flush_out,
    output logic             bus_error,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic             RegWrite_out,
    output logic             MemtoReg_out,
    output logic [Depth-1:0] Read_data_out,
    output logic [Depth-1:0] ALU_result_out,
    output logic [4:0]       Register_dest_out
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic [Depth-1:0] rdata_q, rdata_d;

    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [Depth-1:0] dmem_addr_q, dmem_addr_d;
    logic [Depth-1:0] dmem_wdata_q, dmem_wdata_d;
    logic             bus_error_q, bus_error_d;
    logic             misalign_q, misalign_d;

    logic             regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic [Depth-1:0] read_data_q, read_data_d;
    logic [Depth-1:0] alu_result_q, alu_result_d;
    logic [4:0]       reg_dest_q, reg_dest_d;

    logic             mem_op;
    logic             misaligned;
    logic             timeout_hit;

    assign mem_op      = MemRead_in | MemWrite_in;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned  = (ALU_result_in[1:0] != 2'b00);
`else
    assign misaligned  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        rdata_d      = rdata_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        bus_error_d  = bus_error_q;
        misalign_d   = misalign_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        reg_dest_d   = reg_dest_q;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    // The instruction is held upstream by stall and retires
                    // from DONE, so MEM/WB takes a bubble here.
                    regwrite_d   = 1'b0;
                    memtoreg_d   = 1'b0;
                    read_data_d  = '0;
                    alu_result_d = '0;
                    reg_dest_d   = '0;
                    if (misaligned) begin
                        abort_d    = 1'b1;
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = MemWrite_in;
                        dmem_addr_d  = ALU_result_in;
                        dmem_wdata_d = Read_data1_in;
                        cnt_d        = '0;
                        abort_d      = 1'b0;
                        rdata_d      = '0;
                        state_d      = S_REQ;
                    end
                end else begin
                    regwrite_d   = RegWrite_in;
                    memtoreg_d   = MemtoReg_in;
                    read_data_d  = '0;
                    alu_result_d = ALU_result_in;
                    reg_dest_d   = Register_dest_in;
                end
            end

            S_REQ: begin
                // Ack is tested first so that an ack on the final allowed
                // cycle completes the access instead of aborting it.
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    dmem_req_d  = 1'b0;
                    bus_error_d = 1'b1;
                    abort_d     = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                regwrite_d   = RegWrite_in & ~abort_q;
                memtoreg_d   = MemtoReg_in;
                read_data_d  = abort_q ? '0 : rdata_q;
                alu_result_d = ALU_result_in;
                reg_dest_d   = Register_dest_in;
                abort_d      = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            rdata_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            bus_error_q  <= 1'b0;
            misalign_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            reg_dest_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            rdata_q      <= rdata_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            bus_error_q  <= bus_error_d;
            misalign_q   <= misalign_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_dest_q   <= reg_dest_d;
        end
    end

    // Only the issuing IDLE cycle and the outstanding REQ cycles hold the
    // pipeline; DONE releases it so the next instruction arrives in IDLE.
    assign stall     = ((state_q == S_IDLE) && mem_op) || (state_q == S_REQ);
    assign PCSrc     = (state_q == S_IDLE) && Branch_in && (ALU_result_in == '0);
    assign flush_out = PCSrc;
    assign PC_target = PC_calculated_in;

    assign dmem_req          = dmem_req_q;
    assign dmem_we           = dmem_we_q;
    assign dmem_addr         = dmem_addr_q;
    assign dmem_wdata        = dmem_wdata_q;
    assign bus_error         = bus_error_q;
    assign RegWrite_out      = regwrite_q;
    assign MemtoReg_out      = memtoreg_q;
    assign Read_data_out     = read_data_q;
    assign ALU_result_out    = alu_result_q;
    assign Register_dest_out = reg_dest_q;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [31:0] PC_calculated_in, ALU_result_in, Read_data1_in;
    logic [4:0]  Register_dest_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, PCSrc, flush_out, bus_error;
    logic [31:0] PC_target;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] Read_data_out, ALU_result_out;
    logic [4:0]  Register_dest_out;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_stage_ctrl #(.Width(32), .Depth(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .PC_calculated_in(PC_calculated_in), .ALU_result_in(ALU_result_in),
        .Read_data1_in(Read_data1_in), .Register_dest_in(Register_dest_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .PCSrc(PCSrc), .PC_target(PC_target), .flush_out(flush_out),
        .bus_error(bus_error),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .Read_data_out(Read_data_out), .ALU_result_out(ALU_result_out),
        .Register_dest_out(Register_dest_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        Branch_in = 0; MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
        PC_calculated_in = 0; ALU_result_in = 0; Read_data1_in = 0; Register_dest_in = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic chk_mem_wb(input string tag, input logic rw, input logic m2r,
                              input logic [31:0] rdat, input logic [31:0] alu, input logic [4:0] rd);
        chk({tag, "_regwrite"}, RegWrite_out, rw);
        chk({tag, "_memtoreg"}, MemtoReg_out, m2r);
        chk({tag, "_rdata"}, Read_data_out, rdat);
        chk({tag, "_alu"}, ALU_result_out, alu);
        chk({tag, "_rd"}, Register_dest_out, rd);
    endtask

    // Drives one memory instruction, acks on REQ cycle k (never if k > TO),
    // retires it, then leaves a NOP on the inputs and returns at the negedge
    // where MEM/WB holds the retired instruction.
    task automatic access(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int k, input logic [31:0] rdata,
                          output int stall_n, output int req_n, output logic we_seen,
                          output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
        bit done;
        @(negedge clk);
        Branch_in = 0; MemRead_in = rd_en; MemWrite_in = wr_en; RegWrite_in = rw;
        MemtoReg_in = m2r; ALU_result_in = addr; Read_data1_in = wdata;
        Register_dest_in = rd; PC_calculated_in = 32'h0; dmem_ack = 0;
        stall_n = 0; req_n = 0; done = 0;
        we_seen = 0; addr_seen = 0; wdata_seen = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (stall) stall_n++;
            if (dmem_req) begin
                req_n++;
                if (req_n == 1) begin
                    we_seen = dmem_we; addr_seen = dmem_addr; wdata_seen = dmem_wdata;
                end
            end
            dmem_ack   = dmem_req && (req_n == k);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            if (!stall) done = 1;
            else @(negedge clk);
        end
        chk("access_completes_in_bound", done, 1'b1);
        @(posedge clk);
        #1 set_nop();
        @(negedge clk);
    endtask

    typedef struct {
        logic        br, rw, m2r;
        logic [31:0] alu, pc;
        logic [4:0]  rd;
        logic        e_pcsrc;
    } vec_t;

    vec_t vecs[5];
    logic exp_bus_err;
    int   sn, rn;
    logic we_s;
    logic [31:0] a_s, w_s;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0,        5'd5,  1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h80,       5'd0,  1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h80,       5'd0,  1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h44,       5'd31, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hCAFE_0000, 5'd9, 1'b0};

        set_nop();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_stall", stall, 0);
        chk_mem_wb("rst", 0, 0, 0, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("rst_misalign", misalign, 0);
`endif

        // Single-cycle ALU/branch vectors.
        for (int i = 0; i < 5; i++) begin
            Branch_in = vecs[i].br; RegWrite_in = vecs[i].rw; MemtoReg_in = vecs[i].m2r;
            ALU_result_in = vecs[i].alu; PC_calculated_in = vecs[i].pc;
            Register_dest_in = vecs[i].rd; MemRead_in = 0; MemWrite_in = 0;
            #1;
            chk($sformatf("vec%0d_pcsrc", i), PCSrc, vecs[i].e_pcsrc);
            chk($sformatf("vec%0d_flush", i), flush_out, vecs[i].e_pcsrc);
            chk($sformatf("vec%0d_pc_target", i), PC_target, vecs[i].pc);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            @(negedge clk);
            chk_mem_wb($sformatf("vec%0d", i), vecs[i].rw, vecs[i].m2r, 0, vecs[i].alu, vecs[i].rd);
        end
        set_nop();

        // Load at 0x100, ack on second REQ cycle.
        access(1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 2, 32'hDEAD_BEEF, sn, rn, we_s, a_s, w_s);
        chk("load_stall_cycles", sn, 3);
        chk("load_req_cycles", rn, 2);
        chk("load_addr", a_s, 32'h100);
        chk("load_we", we_s, 0);
        chk_mem_wb("load", 1, 1, 32'hDEAD_BEEF, 32'h100, 5'd7);

        // Store at 0x40, ack on first REQ cycle.
        access(0, 1, 0, 0, 32'h40, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_1111, sn, rn, we_s, a_s, w_s);
        chk("store_stall_cycles", sn, 2);
        chk("store_we", we_s, 1);
        chk("store_wdata", w_s, 32'hA5A5_A5A5);
        chk("store_addr", a_s, 32'h40);
        chk_mem_wb("store", 0, 0, 0, 32'h40, 5'd0);

        // Ack on the last allowed REQ cycle completes the access.
        access(1, 0, 1, 1, 32'h200, 32'h0, 5'd3, TO, 32'h0BAD_F00D, sn, rn, we_s, a_s, w_s);
        chk("edge_ack_req_cycles", rn, TO);
        chk("edge_ack_bus_error", bus_error, 0);
        chk_mem_wb("edge_ack", 1, 1, 32'h0BAD_F00D, 32'h200, 5'd3);

        // No ack: abort after TO REQ cycles.
        access(1, 0, 1, 1, 32'h300, 32'h0, 5'd4, TO + 5, 32'h0, sn, rn, we_s, a_s, w_s);
        chk("timeout_req_cycles", rn, TO);
        chk("timeout_stall_cycles", sn, TO + 1);
        chk("timeout_bus_error", bus_error, 1);
        chk_mem_wb("timeout", 0, 1, 0, 32'h300, 5'd4);
        dmem_ack = 1; dmem_rdata = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_stall", stall, 0);
        chk("late_ack_rdata", Read_data_out, 0);
        chk("late_ack_bus_error", bus_error, 1);
        set_nop();
        exp_bus_err = 1;

        // Randomized instructions against a transaction-level model.
        for (int t = 0; t < 24; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                logic br, rw, m2r;
                logic [31:0] alu, pc;
                logic [4:0] rd;
                br = 1'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
                alu = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                pc = $urandom; rd = 5'($urandom);
                Branch_in = br; RegWrite_in = rw; MemtoReg_in = m2r; ALU_result_in = alu;
                PC_calculated_in = pc; Register_dest_in = rd;
                #1;
                chk($sformatf("rnd%0d_pcsrc", t), PCSrc, br && (alu == 0));
                chk($sformatf("rnd%0d_stall", t), stall, 0);
                @(negedge clk);
                chk_mem_wb($sformatf("rnd%0d", t), rw, m2r, 0, alu, rd);
                set_nop();
            end else begin
                logic rd_en, wr_en, rw, m2r, acked;
                logic [31:0] addr, wdata, rdata;
                logic [4:0] rd;
                int k;
                wr_en = (kind == 2) || ($urandom_range(0, 3) == 0);
                rd_en = (kind == 1);
                rw = 1'($urandom); m2r = 1'($urandom); rd = 5'($urandom);
                addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom; rdata = $urandom;
                k = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 5);
                acked = (k <= TO);
                access(rd_en, wr_en, rw, m2r, addr, wdata, rd, k, rdata, sn, rn, we_s, a_s, w_s);
                exp_bus_err = exp_bus_err | !acked;
                chk($sformatf("rnd%0d_req_cycles", t), rn, acked ? k : TO);
                chk($sformatf("rnd%0d_stall_cycles", t), sn, 1 + (acked ? k : TO));
                chk($sformatf("rnd%0d_we", t), we_s, wr_en);
                chk($sformatf("rnd%0d_addr", t), a_s, addr);
                chk($sformatf("rnd%0d_wdata", t), w_s, wdata);
                chk($sformatf("rnd%0d_bus_error", t), bus_error, exp_bus_err);
                chk_mem_wb($sformatf("rnd%0d", t), acked ? rw : 1'b0, m2r,
                           (acked && !wr_en) ? rdata : 32'h0, addr, rd);
            end
        end

        // Reset while an access is outstanding.
        @(negedge clk);
        MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_result_in = 32'h400;
        Register_dest_in = 5'd12;
        @(negedge clk);
        chk("mid_rst_req_before", dmem_req, 1);
        rst = 1;
        set_nop();
        @(negedge clk);
        rst = 0;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_bus_error", bus_error, 0);
        chk("mid_rst_addr", dmem_addr, 0);
        chk_mem_wb("mid_rst", 0, 0, 0, 0, 0);
        dmem_ack = 1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_ack = 0;
        @(negedge clk);
        chk("post_rst_ack_req", dmem_req, 0);
        chk("post_rst_ack_rdata", Read_data_out, 0);
        chk("post_rst_ack_stall", stall, 0);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned load is retired without a request.
        MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_result_in = 32'h102;
        Register_dest_in = 5'd6;
        #1;
        chk("misalign_stall_idle", stall, 1);
        @(negedge clk);
        chk("misalign_req", dmem_req, 0);
        chk("misalign_flag", misalign, 1);
        chk("misalign_stall_done", stall, 0);
        @(posedge clk);
        #1 set_nop();
        @(negedge clk);
        chk("misalign_regwrite", RegWrite_out, 0);
        chk("misalign_req_after", dmem_req, 0);
        chk("misalign_sticky", misalign, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs and resolves branches. It sequences load/store accesses to the data memory over a req/ack handshake, stalling the upstream pipeline while an access is outstanding. Its MEM/WB register feeds the writeback mux.

Parameters:
Width, 32, PC width
Depth, 32, data/address width
TIMEOUT, 15, max REQ cycles without dmem_ack before abort (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in  input  1 each  control bits from EX/MEM
PC_calculated_in  input  Width  branch target from EX/MEM
ALU_result_in  input  Depth  address / ALU result (branch compare: zero = taken)
Read_data1_in  input  Depth  store data
Register_dest_in  input  5  destination register
dmem_req  output  1  access request (registered)
dmem_we  output  1  1 = store
dmem_addr  output  Depth  access address
dmem_wdata  output  Depth  store data
dmem_ack  input  1  access complete; dmem_rdata valid same cycle
dmem_rdata  input  Depth  load data
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
PCSrc  output  1  branch taken
PC_target  output  Width  = PC_calculated_in
flush_out  output  1  flush younger stages (= PCSrc)
bus_error  output  1  sticky timeout flag
RegWrite_out, MemtoReg_out  output  1 each  MEM/WB control
Read_data_out, ALU_result_out  output  Depth  MEM/WB data
Register_dest_out  output  5  MEM/WB destination

Behaviour:
- Reset: state IDLE, timeout counter 0. All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, bus_error, all MEM/WB outputs. Reset wins over every other event; reset mid-access drops dmem_req next edge, and a late ack is ignored.
- mem_op = MemRead_in | MemWrite_in; MemWrite_in takes priority if both are set.
- States IDLE, REQ, DONE.
- IDLE, no mem_op: MEM/WB loads inputs at the edge (Read_data_out <= 0); stall = 0; 1-cycle latency.
- IDLE, mem_op: stall = 1; MEM/WB loads a bubble (all zero); latch addr/wdata/we, dmem_req <= 1, counter <= 0; go to REQ.
- REQ: stall = 1; dmem_req held with stable addr/we/wdata.
  - dmem_ack: dmem_req <= 0; capture dmem_rdata if load; go to DONE.
  - No ack: counter++. On counter == TIMEOUT-1 with no ack: dmem_req <= 0, bus_error <= 1, abort flag set, go to DONE.
  - Ack in the same cycle as timeout: ack wins.
- DONE: stall = 0. MEM/WB loads RegWrite_in, MemtoReg_in, Register_dest_in, ALU_result_in, captured rdata. If aborted: RegWrite_out <= 0, Read_data_out <= 0. Go to IDLE.
- Access minimum 3 cycles (IDLE, REQ, DONE); ack after k REQ cycles gives 2+k.
- dmem_ack outside REQ is ignored.
- Branch: PCSrc = Branch_in & (ALU_result_in == 0), combinational, state IDLE only; 0 in REQ/DONE. Branch instructions never access memory.
- bus_error clears only on rst.

Optional Feature:
MEM_MISALIGN_CHECK_EN. Defined: a mem_op with ALU_result_in[1:0] != 0 never enters REQ. The block goes IDLE -> DONE with stall = 1 for that IDLE cycle, RegWrite_out suppressed, and output misalign (1 bit, registered, sticky until rst) set. Undefined: no check, no misalign port, and the low address bits pass to dmem_addr unchanged.

Test Plan:
- rst high 2 cycles, then ALU op (RegWrite=1, ALU_result=0x1234, rd=5) -> next edge RegWrite_out=1, ALU_result_out=0x1234, Register_dest_out=5, stall=0.
- Load addr 0x100, ack after 2 REQ cycles with rdata 0xDEADBEEF -> stall high 3 cycles; dmem_req high 2; MEM/WB then Read_data_out=0xDEADBEEF, MemtoReg_out=1.
- Store addr 0x40, data 0xA5A5A5A5, ack first REQ cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5; stall 2 cycles; RegWrite_out=0.
- Load, no ack, TIMEOUT=15 -> dmem_req drops after 15 REQ cycles; bus_error=1; RegWrite_out=0; ack arriving later ignored.
- Branch_in=1, ALU_result=0, PC_calculated=0x80 -> PCSrc=1, flush_out=1, PC_target=0x80. Same with ALU_result=1 -> PCSrc=0.
- rst asserted during REQ -> next edge dmem_req=0, state IDLE, all outputs 0. With MEM_MISALIGN_CHECK_EN: load at 0x102 -> no dmem_req, misalign=1.
